// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer.
// Contents: FSM state enum, opcode constants, ALU operation encodings and
// instruction field positions (byte = {opcode[7:4], imm[3:0]}).
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StFetch2,
        StExec,
        StWb,
        StHalt
    } state_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_BZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_PASS = 3'd5;

    localparam int unsigned OPC_MSB = 7;
    localparam int unsigned OPC_LSB = 4;
    localparam int unsigned IMM_MSB = 3;
    localparam int unsigned IMM_LSB = 0;

endpackage

// File: rtl/cpu_ctrl_sequencer_if.sv
// Instruction-memory fetch interface (req/ack handshake).
// master (sequencer): drives imem_req, imem_addr; receives imem_ack, imem_data.
// slave  (memory)   : the mirror image.
// imem_addr is stable while imem_req=1; imem_data is valid in the ack cycle.
interface cpu_ctrl_sequencer_if #(
    parameter int unsigned PC_W = 8
) ();
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [7:0]      imem_data;

    modport master (output imem_req, imem_addr, input imem_ack, imem_data);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode decoder.
// Ports: opcode_i (instruction [7:4]) -> alu_op_o, is_alu_o (ALU ops and LDI),
// is_jump_o, is_branch_o, is_halt_o, is_illegal_o (opcodes 9-E), two_byte_o.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic [2:0] alu_op_o,
    output logic       is_alu_o,
    output logic       is_jump_o,
    output logic       is_branch_o,
    output logic       is_halt_o,
    output logic       is_illegal_o,
    output logic       two_byte_o
);

    always_comb begin
        alu_op_o     = ALU_ADD;
        is_alu_o     = 1'b0;
        is_jump_o    = 1'b0;
        is_branch_o  = 1'b0;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;
        case (opcode_i)
            OP_NOP: ;
            OP_ADD: begin alu_op_o = ALU_ADD;  is_alu_o = 1'b1; end
            OP_SUB: begin alu_op_o = ALU_SUB;  is_alu_o = 1'b1; end
            OP_AND: begin alu_op_o = ALU_AND;  is_alu_o = 1'b1; end
            OP_OR:  begin alu_op_o = ALU_OR;   is_alu_o = 1'b1; end
            OP_XOR: begin alu_op_o = ALU_XOR;  is_alu_o = 1'b1; end
            OP_LDI: begin alu_op_o = ALU_PASS; is_alu_o = 1'b1; end
            OP_JMP: is_jump_o   = 1'b1;
            OP_BZ:  is_branch_o = 1'b1;
            OP_HLT: is_halt_o   = 1'b1;
            default: is_illegal_o = 1'b1;
        endcase
    end

    assign two_byte_o = is_jump_o | is_branch_o;

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// Multi-cycle control sequencer: fetches instruction bytes over a req/ack
// handshake, decodes them and drives the ALU/accumulator controls. Owns the
// PC, zero flag, halt state and a saturating retired-instruction counter.
// Ports: clk, reset (async, active low), start, imem (fetch interface, master),
// alu_op/alu_operand/alu_zero/reg_we (datapath), pc_out, halted, illegal,
// instr_count.
// Optional: define CTRL_BREAKPOINT_EN to add bp_addr/bp_valid/bp_hit; a fetch
// at bp_addr then returns to IDLE without issuing a request.
module cpu_ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    cpu_ctrl_sequencer_if.master imem,
    output logic [2:0]           alu_op,
    output logic [DATA_W-1:0]    alu_operand,
    input  logic                 alu_zero,
    output logic                 reg_we,
    output logic [PC_W-1:0]      pc_out,
    output logic                 halted,
`ifdef CTRL_BREAKPOINT_EN
    input  logic [PC_W-1:0]      bp_addr,
    input  logic                 bp_valid,
    output logic                 bp_hit,
`endif
    output logic                 illegal,
    output logic [CNT_W-1:0]     instr_count
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   tgt_q, tgt_d;
    logic [7:0]        ir_q, ir_d;
    logic              z_q, z_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              retire;
    logic              bp_trap;

    logic [2:0] dec_alu_op;
    logic       dec_alu, dec_jump, dec_branch, dec_halt, dec_illegal, dec_two_byte;

    cpu_ctrl_decode u_decode (
        .opcode_i     (ir_q[OPC_MSB:OPC_LSB]),
        .alu_op_o     (dec_alu_op),
        .is_alu_o     (dec_alu),
        .is_jump_o    (dec_jump),
        .is_branch_o  (dec_branch),
        .is_halt_o    (dec_halt),
        .is_illegal_o (dec_illegal),
        .two_byte_o   (dec_two_byte)
    );

`ifdef CTRL_BREAKPOINT_EN
    // bp_skip: the fetch right after a trap must not re-trap.
    // bp_live: a request is already outstanding, so the check is only made on
    // the first FETCH cycle and never yanks a held request.
    logic bp_skip_q, bp_skip_d, bp_live_q, bp_live_d;

    always_comb begin
        bp_trap   = (state_q == StFetch) && !bp_live_q && !bp_skip_q && bp_valid &&
                    (pc_q == bp_addr);
        bp_skip_d = bp_skip_q;
        if (bp_trap) begin
            bp_skip_d = 1'b1;
        end else if (state_q == StFetch && imem.imem_ack) begin
            bp_skip_d = 1'b0;
        end
        bp_live_d = (state_q == StFetch) && !bp_trap && !imem.imem_ack;
    end

    assign bp_hit = bp_trap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bp_skip_q <= 1'b0;
            bp_live_q <= 1'b0;
        end else begin
            bp_skip_q <= bp_skip_d;
            bp_live_q <= bp_live_d;
        end
    end
`else
    assign bp_trap = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        tgt_d         = tgt_q;
        ir_d          = ir_q;
        z_d           = z_q;
        retire        = 1'b0;
        imem.imem_req = 1'b0;
        alu_op        = 3'd0;
        alu_operand   = '0;
        reg_we        = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                if (bp_trap) begin
                    state_d = StIdle;
                end else begin
                    imem.imem_req = 1'b1;
                    if (imem.imem_ack) begin
                        ir_d    = imem.imem_data;
                        pc_d    = pc_q + PC_W'(1);
                        state_d = StDecode;
                    end
                end
            end
            StDecode: begin
                illegal = dec_illegal;
                if (dec_two_byte) begin
                    state_d = StFetch2;
                end else if (dec_halt) begin
                    state_d = StHalt;
                end else if (dec_alu) begin
                    state_d = StExec;
                end else begin
                    // NOP and illegal opcodes retire here
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch2: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    tgt_d   = PC_W'(imem.imem_data);
                    pc_d    = pc_q + PC_W'(1);
                    state_d = StExec;
                end
            end
            StExec: begin
                if (dec_alu) begin
                    alu_op      = dec_alu_op;
                    alu_operand = DATA_W'(ir_q[IMM_MSB:IMM_LSB]);
                    state_d     = StWb;
                end else begin
                    if (dec_jump || (dec_branch && z_q)) pc_d = tgt_q;
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StWb: begin
                alu_op      = dec_alu_op;
                alu_operand = DATA_W'(ir_q[IMM_MSB:IMM_LSB]);
                reg_we      = 1'b1;
                z_d         = alu_zero;
                retire      = 1'b1;
                state_d     = StFetch;
            end
            StHalt: ;
            default: state_d = StIdle;
        endcase

        cnt_d = (retire && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            tgt_q   <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign pc_out         = pc_q;
    assign halted         = (state_q == StHalt);
    assign instr_count    = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Self-checking bench for cpu_ctrl_sequencer: table of single-instruction
// vectors plus hand-written multi-cycle sequences.
module tb_cpu_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  alu_op;
    logic [3:0]  alu_operand;
    logic        zero_in;
    logic        reg_we;
    logic [7:0]  pc_out;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_count;
`ifdef CTRL_BREAKPOINT_EN
    logic [7:0]  bp_addr;
    logic        bp_valid;
    logic        bp_hit;
`endif

    logic [7:0] mem [256];
    int         ack_delay;
    int         wait_cnt;

    int checks = 0;
    int errors = 0;

    cpu_ctrl_sequencer_if #(.PC_W(8)) imem_if ();

    cpu_ctrl_sequencer #(.PC_W(8), .DATA_W(4), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .imem        (imem_if.master),
        .alu_op      (alu_op),
        .alu_operand (alu_operand),
        .alu_zero    (zero_in),
        .reg_we      (reg_we),
        .pc_out      (pc_out),
        .halted      (halted),
`ifdef CTRL_BREAKPOINT_EN
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
        .bp_hit      (bp_hit),
`endif
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Memory model: acks after ack_delay waiting cycles.
    assign imem_if.imem_ack  = imem_if.imem_req && (wait_cnt >= ack_delay);
    assign imem_if.imem_data = mem[imem_if.imem_addr];

    always @(posedge clk or negedge reset) begin
        if (!reset) wait_cnt <= 0;
        else if (imem_if.imem_req && !imem_if.imem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // Monitor, sampled on the falling edge.
    int cyc = 0;
    int we_n = 0, ill_n = 0, fa_n = 0, bp_n = 0;
    int we_cyc [256];
    int we_op  [256];
    int we_opd [256];
    int we_pc  [256];
    int we_cnt [256];
    int fa     [256];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_we) begin
            we_cyc[we_n % 256] = cyc;
            we_op[we_n % 256]  = int'(alu_op);
            we_opd[we_n % 256] = int'(alu_operand);
            we_pc[we_n % 256]  = int'(pc_out);
            we_cnt[we_n % 256] = int'(instr_count);
            we_n++;
        end
        if (illegal) ill_n++;
        if (imem_if.imem_req && imem_if.imem_ack) begin
            fa[fa_n % 256] = int'(imem_if.imem_addr);
            fa_n++;
        end
`ifdef CTRL_BREAKPOINT_EN
        if (bp_hit) bp_n++;
`endif
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);
    endtask

    task automatic fill_hlt();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         op;
        int         opd;
        int         we;
        int         ill;
        int         pc;
        int         cnt;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int b, n, first, wb, ib;

        // instr, 2nd byte, alu_op, operand, reg_we pulses, illegal pulses, final pc, count
        vecs[0]  = '{8'h00, 8'hF0, 0, 0, 0, 0, 8'h02, 1};
        vecs[1]  = '{8'h13, 8'hF0, 0, 3, 1, 0, 8'h02, 1};
        vecs[2]  = '{8'h2A, 8'hF0, 1, 10, 1, 0, 8'h02, 1};
        vecs[3]  = '{8'h34, 8'hF0, 2, 4, 1, 0, 8'h02, 1};
        vecs[4]  = '{8'h4F, 8'hF0, 3, 15, 1, 0, 8'h02, 1};
        vecs[5]  = '{8'h51, 8'hF0, 4, 1, 1, 0, 8'h02, 1};
        vecs[6]  = '{8'h67, 8'hF0, 5, 7, 1, 0, 8'h02, 1};
        vecs[7]  = '{8'h70, 8'h10, 0, 0, 0, 0, 8'h11, 1};
        vecs[8]  = '{8'h80, 8'h20, 0, 0, 0, 0, 8'h03, 1};
        vecs[9]  = '{8'hC5, 8'hF0, 0, 0, 0, 1, 8'h02, 1};
        vecs[10] = '{8'hF3, 8'hF0, 0, 0, 0, 0, 8'h01, 0};

        ack_delay = 0;
        zero_in   = 1'b0;
`ifdef CTRL_BREAKPOINT_EN
        bp_addr  = 8'h00;
        bp_valid = 1'b0;
`endif
        fill_hlt();

        // Reset and idle
        do_reset();
        step(10);
        chk("idle_req", int'(imem_if.imem_req), 0);
        chk("idle_pc", int'(pc_out), 0);
        chk("idle_we", int'(reg_we), 0);
        chk("idle_halted", int'(halted), 0);
        chk("idle_illegal", int'(illegal), 0);
        chk("idle_count", int'(instr_count), 0);
        chk("idle_aluop", int'(alu_op), 0);
        chk("idle_operand", int'(alu_operand), 0);

        // Table: one instruction then HLT
        for (int v = 0; v < 11; v++) begin
            do_reset();
            fill_hlt();
            mem[0] = vecs[v].b0;
            mem[1] = vecs[v].b1;
            b  = we_n;
            ib = ill_n;
            pulse_start();
            step(20);
            chk($sformatf("v%0d_we", v), we_n - b, vecs[v].we);
            if (vecs[v].we > 0) begin
                chk($sformatf("v%0d_op", v), we_op[b % 256], vecs[v].op);
                chk($sformatf("v%0d_opd", v), we_opd[b % 256], vecs[v].opd);
            end
            chk($sformatf("v%0d_ill", v), ill_n - ib, vecs[v].ill);
            chk($sformatf("v%0d_pc", v), int'(pc_out), vecs[v].pc);
            chk($sformatf("v%0d_cnt", v), int'(instr_count), vecs[v].cnt);
            chk($sformatf("v%0d_halted", v), int'(halted), 1);
        end

        // Straight-line LDI 5, SUB 3
        do_reset();
        fill_hlt();
        mem[0] = 8'h65;
        mem[1] = 8'h23;
        b = we_n;
        pulse_start();
        step(25);
        chk("sl_we_n", we_n - b, 2);
        chk("sl_spacing", we_cyc[(b + 1) % 256] - we_cyc[b % 256], 4);
        chk("sl_op0", we_op[b % 256], 5);
        chk("sl_opd0", we_opd[b % 256], 5);
        chk("sl_op1", we_op[(b + 1) % 256], 1);
        chk("sl_opd1", we_opd[(b + 1) % 256], 3);
        chk("sl_pc_at_wb", we_pc[(b + 1) % 256], 2);
        chk("sl_count", int'(instr_count), 2);

        // Wait states on the first fetch
        do_reset();
        fill_hlt();
        mem[0]    = 8'h65;
        ack_delay = 3;
        b         = we_n;
        pulse_start();
        n     = 0;
        first = cyc;
        for (int i = 0; i < 20; i++) begin
            if (imem_if.imem_req && imem_if.imem_addr == 8'h00) begin
                if (n == 0) first = cyc;
                n++;
            end else if (n > 0) begin
                break;
            end
            step(1);
        end
        ack_delay = 0;
        chk("ws_req_held", n, 4);
        step(15);
        chk("ws_we_n", we_n - b, 1);
        wb = we_cyc[b % 256];
        chk("ws_latency", wb - first, 6);
        chk("ws_opd", we_opd[b % 256], 5);

        // Branch taken: LDI 0 (zero), BZ 0x40, JMP 0x10
        do_reset();
        fill_hlt();
        mem[8'h00] = 8'h60;
        mem[8'h01] = 8'h80;
        mem[8'h02] = 8'h40;
        mem[8'h40] = 8'h70;
        mem[8'h41] = 8'h10;
        zero_in    = 1'b1;
        b          = fa_n;
        pulse_start();
        step(30);
        chk("bz_t_addr", fa[(b + 3) % 256], 8'h40);
        chk("bz_t_jmp", fa[(b + 5) % 256], 8'h10);
        chk("bz_t_pc", int'(pc_out), 8'h11);
        chk("bz_t_cnt", int'(instr_count), 3);

        // Branch not taken
        do_reset();
        zero_in = 1'b0;
        b       = fa_n;
        pulse_start();
        step(30);
        chk("bz_n_addr", fa[(b + 3) % 256], 8'h03);
        chk("bz_n_pc", int'(pc_out), 8'h04);
        chk("bz_n_cnt", int'(instr_count), 2);

        // Wrap, illegal, halt
        do_reset();
        fill_hlt();
        mem[8'h00] = 8'h70;
        mem[8'h01] = 8'hFF;
        mem[8'hFF] = 8'h9A;
        b  = fa_n;
        ib = ill_n;
        pulse_start();
        for (int i = 0; i < 20 && fa_n < b + 2; i++) step(1);
        mem[8'h00] = 8'hF0;
        step(20);
        chk("wr_ill", ill_n - ib, 1);
        chk("wr_ff", fa[(b + 2) % 256], 8'hFF);
        chk("wr_00", fa[(b + 3) % 256], 8'h00);
        chk("wr_halted", int'(halted), 1);
        chk("wr_pc", int'(pc_out), 8'h01);
        chk("wr_cnt", int'(instr_count), 2);
        n = fa_n;
        for (int i = 0; i < 3; i++) begin
            pulse_start();
            step(2);
        end
        chk("hlt_stays", int'(halted), 1);
        chk("hlt_no_req", int'(imem_if.imem_req), 0);
        chk("hlt_no_fetch", fa_n - n, 0);
        do_reset();
        chk("hlt_cleared", int'(halted), 0);
        chk("hlt_pc0", int'(pc_out), 0);

        // Reset abandons an outstanding request
        ack_delay = 10;
        pulse_start();
        step(2);
        reset = 1'b0;
        #1;
        chk("rst_abandon_req", int'(imem_if.imem_req), 0);
        step(2);
        reset     = 1'b1;
        ack_delay = 0;
        step(2);
        chk("rst_idle_req", int'(imem_if.imem_req), 0);

`ifdef CTRL_BREAKPOINT_EN
        // Breakpoint at 0x02 after two NOPs
        do_reset();
        fill_hlt();
        mem[0] = 8'h00;
        mem[1] = 8'h00;
        mem[2] = 8'h00;
        bp_addr  = 8'h02;
        bp_valid = 1'b1;
        b = bp_n;
        n = fa_n;
        pulse_start();
        step(15);
        chk("bp_hits", bp_n - b, 1);
        chk("bp_pc", int'(pc_out), 8'h02);
        chk("bp_no_req", int'(imem_if.imem_req), 0);
        chk("bp_fetches", fa_n - n, 2);
        pulse_start();
        step(15);
        chk("bp_no_retrap", bp_n - b, 1);
        chk("bp_resume_addr", fa[(n + 2) % 256], 8'h02);
        chk("bp_halted", int'(halted), 1);
        bp_valid = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_sequencer.md
Name: cpu_ctrl_sequencer

Overview:
- Multi-cycle control sequencer for the 8-bit-PC / 4-bit-ALU CPU core.
- Fetches instructions from instruction memory over a req/ack handshake and decodes them.
- Drives ALU op, operand and register write-enable, and owns the PC, zero flag and halt state.
- Sits between instruction memory and the ALU/register datapath; pc_out feeds the top-level observation ports.

Parameters:
- PC_W, 8, program counter and instruction-memory address width.
- DATA_W, 4, ALU operand width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE and begin fetching at the current PC.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address; stable while imem_req=1.
- imem_ack  in  1  fetch complete; imem_data is valid in this cycle.
- imem_data  in  8  instruction byte.
- alu_op  out  3  ALU operation select.
- alu_operand  out  DATA_W  immediate operand to the ALU.
- alu_zero  in  1  ALU result == 0.
- reg_we  out  1  accumulator write-enable, one-cycle pulse.
- pc_out  out  PC_W  current PC.
- halted  out  1  HLT executed.
- illegal  out  1  one-cycle pulse when an undefined opcode is decoded.
- instr_count  out  CNT_W  retired instructions; saturates at all-ones.

Behaviour:
- Reset:
  - reset=0 asynchronously forces state IDLE.
  - All outputs go to 0: pc_out=0x00, imem_req=0, reg_we=0, halted=0, illegal=0, instr_count=0, alu_op=0, alu_operand=0.
  - z_flag is cleared.
  - An outstanding request is abandoned immediately; a late ack is ignored.
- Instruction byte: [7:4] opcode, [3:0] immediate.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: alu_op = opcode-1, alu_operand = imm.
  - 6 LDI: alu_op=5, pass-through.
  - 7 JMP and 8 BZ: two-byte instructions; the second byte is the absolute target.
  - F HLT.
  - 9–E: illegal; pulse illegal, then execute as NOP.
- FSM states: IDLE, FETCH, DECODE, FETCH2, EXEC, WB, HALT.
  - IDLE: wait for start=1, then go to FETCH. start is ignored in every other state.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack: latch imem_data into ir, set pc=pc+1, go to DECODE. Without ack, hold req and addr unchanged (unbounded wait).
  - DECODE:
    - JMP/BZ → FETCH2.
    - HLT → HALT.
    - ALU/LDI → EXEC.
    - NOP/illegal → FETCH, retire instruction.
  - FETCH2: same handshake as FETCH, at address pc. On ack: latch target, pc=pc+1, go to EXEC.
  - EXEC:
    - ALU/LDI: drive alu_op/alu_operand, go to WB.
    - JMP: pc=target.
    - BZ: pc=target if z_flag=1, else unchanged.
    - JMP/BZ then go to FETCH and retire.
  - WB: alu_op/alu_operand stay driven; reg_we=1 for exactly this cycle; z_flag<=alu_zero; retire; go to FETCH.
  - HALT: halted=1, imem_req=0. Only reset exits.
- Latency with ack in the first request cycle:
  - ALU op: 4 cycles per instruction.
  - JMP/BZ: 4 cycles.
  - NOP: 2 cycles.
  - Each wait cycle on ack adds 1 cycle.
- Arithmetic:
  - pc increments modulo 2^PC_W, so 0xFF wraps to 0x00, including during FETCH2.
  - instr_count saturates and never wraps.
  - z_flag changes only in WB; BZ tests the flag left by the last ALU instruction.
- imem_req deasserts the cycle after ack. It never stays high across DECODE.

Optional Feature:
- Macro: CTRL_BREAKPOINT_EN.
- Defined:
  - Adds ports bp_addr in PC_W, bp_valid in 1, bp_hit out 1.
  - On entry to FETCH, if bp_valid=1 and pc==bp_addr: no request is issued, bp_hit pulses for one cycle, state goes to IDLE, pc is preserved.
  - The next start fetches that PC. The breakpoint is suppressed for exactly that one fetch, so execution does not re-trap.
- Undefined: ports absent; FETCH never traps.

Decomposition:
- Package cpu_ctrl_pkg:
  - state enum.
  - opcode constants (OP_NOP…OP_HLT).
  - ALU op encodings.
  - instruction field slice positions.
- Sub-module cpu_ctrl_decode: combinational opcode → {alu_op, is_alu, is_jump, is_branch, is_halt, is_illegal, two_byte}. The FSM stays in the top.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, release, start stays 0 for 10 cycles → imem_req=0, pc_out=0x00, all outputs 0.
- Straight-line ALU: program 0x65 (LDI 5), 0x23 (SUB 3), ack in the same cycle as req → reg_we pulses 4 cycles apart, alu_op=5 then 1, operands 5 then 3, pc_out=0x02, instr_count=2.
- Wait states: delay ack by 3 cycles on the first fetch → imem_req and imem_addr=0x00 held stable for 4 cycles; total latency 7 cycles.
- Branch: LDI 0 with alu_zero=1, then BZ 0x40, then JMP 0x10; and the same BZ with z_flag=0 → next fetch address 0x40 when taken, 0x03 when not taken.
- Wrap, illegal, halt: JMP 0xFF, byte at 0xFF = 0x9A → illegal pulses 1 cycle, pc wraps to 0x00; byte at 0x00 = 0xF0 → halted=1 and remains set under start pulses until reset.
- Breakpoint (CTRL_BREAKPOINT_EN): bp_addr=0x02, bp_valid=1 → bp_hit pulses, state IDLE with pc=0x02 and no request issued; start → fetch at 0x02 proceeds without re-trapping.
